// File: rtl/random_start_timer_if.sv
// Handshake bundle between the game controller and the random start timer.
// The controller is the master and the timer is the slave.
interface random_start_timer_if #(
  parameter int CNT_W = 12
);
  logic             tick;
  logic             rin;
  logic             start;
  logic             abort;
  logic             btn_any;
  logic             busy;
  logic             go;
  logic             foul;
  logic [CNT_W-1:0] delay_val;

  modport master (
    output tick, rin, start, abort, btn_any,
    input  busy, go, foul, delay_val
  );

  modport slave (
    input  tick, rin, start, abort, btn_any,
    output busy, go, foul, delay_val
  );
endinterface

// File: rtl/random_start_timer.sv
// Collects RAND_BITS serial LFSR bits, counts MIN_DELAY + rand game ticks, then opens
// a round with go. A button press while waiting is a false start and raises foul.
module random_start_timer #(
  parameter int RAND_BITS = 8,
  parameter int MIN_DELAY = 500,
  parameter int CNT_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  random_start_timer_if.slave         bus
);

  localparam int BC_W = (RAND_BITS > 2) ? $clog2(RAND_BITS) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_GO      = 3'd3;
  localparam logic [2:0] ST_FOUL    = 3'd4;

  logic [2:0]           state_r;
  logic [2:0]           state_nxt_s;
  // Only the older RAND_BITS-1 bits are stored; the newest bit comes straight from rin.
  logic [RAND_BITS-2:0] shreg_r;
  logic [RAND_BITS-2:0] shreg_nxt_s;
  logic [BC_W-1:0]      bitcnt_r;
  logic [BC_W-1:0]      bitcnt_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [CNT_W-1:0]     dly_r;
  logic [CNT_W-1:0]     dly_nxt_s;
  logic                 busy_r;
  logic                 go_r;
  logic                 foul_r;
  logic [RAND_BITS-1:0] rand_s;
  logic [CNT_W-1:0]     load_s;

  assign rand_s = {shreg_r, bus.rin};
  assign load_s = CNT_W'(MIN_DELAY) + CNT_W'(rand_s);

  // Next-state and datapath decision, abort first, then button, tick expiry, start.
  always_comb begin
    state_nxt_s  = state_r;
    shreg_nxt_s  = shreg_r;
    bitcnt_nxt_s = bitcnt_r;
    cnt_nxt_s    = cnt_r;
    dly_nxt_s    = dly_r;
    if (bus.abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_GO, ST_FOUL: begin
          if (bus.start) begin
            state_nxt_s  = ST_COLLECT;
            shreg_nxt_s  = '0;
            bitcnt_nxt_s = '0;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_COLLECT: begin
          shreg_nxt_s = rand_s[RAND_BITS-2:0];
          if (bitcnt_r == BC_W'(RAND_BITS - 1)) begin
            bitcnt_nxt_s = '0;
            cnt_nxt_s    = load_s;
            dly_nxt_s    = load_s;
            state_nxt_s  = ST_WAIT;
          end else begin
            bitcnt_nxt_s = bitcnt_r + BC_W'(1);
          end
        end
        ST_WAIT: begin
          if (bus.btn_any) begin
            state_nxt_s = ST_FOUL;
          end else if (bus.tick && (cnt_r == CNT_W'(1))) begin
            state_nxt_s = ST_GO;
          end else if (bus.tick) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and state-decoded output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      shreg_r  <= '0;
      bitcnt_r <= '0;
      cnt_r    <= '0;
      dly_r    <= '0;
      busy_r   <= 1'b0;
      go_r     <= 1'b0;
      foul_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shreg_r  <= shreg_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      cnt_r    <= cnt_nxt_s;
      dly_r    <= dly_nxt_s;
      busy_r   <= (state_nxt_s == ST_COLLECT) || (state_nxt_s == ST_WAIT);
      go_r     <= (state_nxt_s == ST_GO);
      foul_r   <= (state_nxt_s == ST_FOUL);
    end
  end

  assign bus.busy      = busy_r;
  assign bus.go        = go_r;
  assign bus.foul      = foul_r;
  assign bus.delay_val = dly_r;

endmodule

// File: tb/tb_random_start_timer.sv
// Directed bench for random_start_timer: a small (4-bit, min 3) and a full-size
// (8-bit, min 500) instance, each compared every cycle against a tick-counting model.
module tb_random_start_timer;

  localparam int CW = 12;
  localparam int P_IDLE = 0, P_COL = 1, P_WAIT = 2, P_GO = 3, P_FOUL = 4;

  typedef struct {
    int phase;
    int nbits;
    int acc;
    int ticks;
    int target;
    int dval;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] tick_v, rin_v, start_v, abort_v, btn_v;
  logic [1:0] busy_o, go_o, foul_o;
  logic [CW-1:0] dv_o [2];
  mdl_t m [2];
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  random_start_timer_if #(.CNT_W(CW)) if_a ();
  random_start_timer_if #(.CNT_W(CW)) if_b ();

  assign if_a.tick    = tick_v[0];
  assign if_a.rin     = rin_v[0];
  assign if_a.start   = start_v[0];
  assign if_a.abort   = abort_v[0];
  assign if_a.btn_any = btn_v[0];
  assign if_b.tick    = tick_v[1];
  assign if_b.rin     = rin_v[1];
  assign if_b.start   = start_v[1];
  assign if_b.abort   = abort_v[1];
  assign if_b.btn_any = btn_v[1];
  assign busy_o = {if_b.busy, if_a.busy};
  assign go_o   = {if_b.go, if_a.go};
  assign foul_o = {if_b.foul, if_a.foul};
  assign dv_o[0] = if_a.delay_val;
  assign dv_o[1] = if_b.delay_val;

  random_start_timer #(.RAND_BITS(4), .MIN_DELAY(3), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  random_start_timer #(.RAND_BITS(8), .MIN_DELAY(500), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  // Round model: count ticks seen since the delay was drawn and compare to the target.
  function automatic mdl_t step(mdl_t mi, int rb, int mn,
                                logic tk, logic r, logic st, logic ab, logic bt);
    mdl_t mo = mi;
    if (ab) begin
      mo.phase = P_IDLE;
      return mo;
    end
    case (mi.phase)
      P_COL: begin
        mo.acc = mi.acc * 2 + int'(r);
        mo.nbits = mi.nbits + 1;
        if (mo.nbits == rb) begin
          mo.target = mn + mo.acc;
          mo.dval = mo.target;
          mo.ticks = 0;
          mo.phase = P_WAIT;
        end
      end
      P_WAIT: begin
        if (bt) mo.phase = P_FOUL;
        else if (tk) begin
          mo.ticks = mi.ticks + 1;
          if (mo.ticks == mi.target) mo.phase = P_GO;
        end
      end
      default: begin
        if (st) begin
          mo.phase = P_COL;
          mo.nbits = 0;
          mo.acc = 0;
        end
      end
    endcase
    return mo;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
    end else begin
      m[0] <= step(m[0], 4, 3, tick_v[0], rin_v[0], start_v[0], abort_v[0], btn_v[0]);
      m[1] <= step(m[1], 8, 500, tick_v[1], rin_v[1], start_v[1], abort_v[1], btn_v[1]);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy[%0d]", i), 32'(busy_o[i]),
          32'((m[i].phase == P_COL) || (m[i].phase == P_WAIT)));
      chk($sformatf("go[%0d]", i), 32'(go_o[i]), 32'(m[i].phase == P_GO));
      chk($sformatf("foul[%0d]", i), 32'(foul_o[i]), 32'(m[i].phase == P_FOUL));
      chk($sformatf("delay_val[%0d]", i), 32'(dv_o[i]), 32'(m[i].dval));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_in(int i, int rb, logic [9:0] bits);
    for (int k = rb - 1; k >= 0; k--) begin
      rin_v[i] = bits[k];
      cyc(1);
    end
    rin_v[i] = 1'b0;
  endtask

  task automatic load(int i, int rb, logic [9:0] bits);
    start_v[i] = 1'b1;
    cyc(1);
    start_v[i] = 1'b0;
    shift_in(i, rb, bits);
  endtask

  task automatic tick_n(int i, int n, int gap);
    repeat (n) begin
      tick_v[i] = 1'b1;
      cyc(1);
      tick_v[i] = 1'b0;
      cyc(gap - 1);
    end
  endtask

  initial begin
    tick_v = '0; rin_v = '0; start_v = '0; abort_v = '0; btn_v = '0;
    cyc(3);
    chk("reset_busy_a", 32'(busy_o[0]), 32'd0);
    chk("reset_dv_b", 32'(dv_o[1]), 32'd0);
    rst = 1'b1;
    cyc(1);

    // Asynchronous reset in the middle of a countdown (counter at 37).
    load(1, 8, 10'h000);
    chk("b_min_delay", 32'(dv_o[1]), 32'd500);
    tick_n(1, 463, 1);
    chk("b_still_busy", 32'(busy_o[1]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", 32'(busy_o[1]), 32'd0);
    chk("async_go", 32'(go_o[1]), 32'd0);
    chk("async_foul", 32'(foul_o[1]), 32'd0);
    chk("async_dv", 32'(dv_o[1]), 32'd0);
    cyc(1);
    rst = 1'b1;
    cyc(100);
    chk("idle_busy", 32'(busy_o[1]), 32'd0);
    chk("idle_go", 32'(go_o[1]), 32'd0);

    // Small instance: load 3 + 4'b1011 = 14, start during COLLECT ignored.
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    chk("a_busy_clk1", 32'(busy_o[0]), 32'd1);
    rin_v[0] = 1'b1; cyc(1);
    rin_v[0] = 1'b0; start_v[0] = 1'b1; cyc(1);
    start_v[0] = 1'b0;
    rin_v[0] = 1'b1; cyc(1);
    chk("a_dv_before_load", 32'(dv_o[0]), 32'd0);
    rin_v[0] = 1'b1; cyc(1);
    rin_v[0] = 1'b0;
    chk("a_dv_load", 32'(dv_o[0]), 32'd14);
    chk("model_dv_load", 32'(m[0].dval), 32'd14);
    start_v[0] = 1'b1; cyc(1); start_v[0] = 1'b0;
    chk("a_start_in_wait_dv", 32'(dv_o[0]), 32'd14);
    chk("a_start_in_wait_busy", 32'(busy_o[0]), 32'd1);
    tick_n(0, 13, 5);
    chk("a_go_after_13", 32'(go_o[0]), 32'd0);
    tick_n(0, 1, 5);
    chk("a_go_after_14", 32'(go_o[0]), 32'd1);
    chk("a_busy_in_go", 32'(busy_o[0]), 32'd0);
    chk("model_go_after_14", 32'(m[0].phase == P_GO), 32'd1);
    btn_v[0] = 1'b1;
    tick_n(0, 3, 2);
    btn_v[0] = 1'b0;
    chk("a_go_held", 32'(go_o[0]), 32'd1);
    chk("a_no_foul_in_go", 32'(foul_o[0]), 32'd0);

    // Start in GO restarts; then a false start after 6 ticks.
    start_v[0] = 1'b1; cyc(1); start_v[0] = 1'b0;
    chk("a_go_drops", 32'(go_o[0]), 32'd0);
    chk("a_recollect_busy", 32'(busy_o[0]), 32'd1);
    shift_in(0, 4, 10'b1011);
    chk("a_dv_reload", 32'(dv_o[0]), 32'd14);
    tick_n(0, 6, 5);
    tick_v[0] = 1'b1; btn_v[0] = 1'b1; cyc(1);
    tick_v[0] = 1'b0; btn_v[0] = 1'b0;
    chk("a_foul", 32'(foul_o[0]), 32'd1);
    chk("a_foul_no_go", 32'(go_o[0]), 32'd0);
    tick_n(0, 10, 1);
    chk("a_foul_held_no_go", 32'(go_o[0]), 32'd0);

    // Abort together with a button in WAIT: back to IDLE, delay held.
    load(0, 4, 10'b0101);
    chk("a_dv_8", 32'(dv_o[0]), 32'd8);
    tick_n(0, 2, 1);
    abort_v[0] = 1'b1; btn_v[0] = 1'b1; cyc(1);
    abort_v[0] = 1'b0; btn_v[0] = 1'b0;
    chk("a_abort_foul", 32'(foul_o[0]), 32'd0);
    chk("a_abort_busy", 32'(busy_o[0]), 32'd0);
    chk("a_abort_dv_held", 32'(dv_o[0]), 32'd8);

    // Full-size maximum delay: 500 + 255 = 755 ticks.
    load(1, 8, 10'h0FF);
    chk("b_max_delay", 32'(dv_o[1]), 32'd755);
    tick_n(1, 754, 1);
    chk("b_go_at_754", 32'(go_o[1]), 32'd0);
    tick_n(1, 1, 1);
    chk("b_go_at_755", 32'(go_o[1]), 32'd1);
    start_v[1] = 1'b1; cyc(1); start_v[1] = 1'b0;
    chk("b_go_drops", 32'(go_o[1]), 32'd0);
    chk("b_collect_busy", 32'(busy_o[1]), 32'd1);
    cyc(8);
    chk("b_reload_min", 32'(dv_o[1]), 32'd500);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
